// File: rtl/wb_regfile_pkg.sv
// Shared widths, defaults and writeback-source encoding for the writeback stage
// and its register file.
package wb_regfile_pkg;

    localparam int unsigned DSIZE_DEF       = 32;
    localparam int unsigned ISIZE_DEF       = 32;
    localparam int unsigned ASIZE_DEF       = 5;
    localparam int unsigned LINK_OFFSET_DEF = 1;
    localparam int unsigned REG_ZERO        = 0;
    localparam int unsigned CNT_W           = 32;

    typedef enum logic [1:0] {
        WbAlu  = 2'd0,
        WbMem  = 2'd1,
        WbLink = 2'd2
    } wb_sel_e;

    // jal outranks MemtoReg: a jal never loads, so the link value must win.
    function automatic wb_sel_e wb_select(input logic jal, input logic mem_to_reg);
        wb_sel_e sel;
        if (jal) begin
            sel = WbLink;
        end else if (mem_to_reg) begin
            sel = WbMem;
        end else begin
            sel = WbAlu;
        end
        return sel;
    endfunction

endpackage

// File: rtl/wb_regfile_2r1w.sv
// Two-read/one-write architectural register file: register 0 reads as zero,
// reads bypass the same-cycle write.
module regfile_2r1w
    import wb_regfile_pkg::*;
#(
    parameter int unsigned DSIZE = DSIZE_DEF,
    parameter int unsigned ASIZE = ASIZE_DEF
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             we_i,
    input  logic [ASIZE-1:0] waddr_i,
    input  logic [DSIZE-1:0] wdata_i,
    input  logic [ASIZE-1:0] raddr1_i,
    input  logic [ASIZE-1:0] raddr2_i,
    output logic [DSIZE-1:0] rdata1_o,
    output logic [DSIZE-1:0] rdata2_o
);

    localparam int unsigned NRegs = 2 ** ASIZE;

    logic [DSIZE-1:0] regs_q [NRegs];
    logic             we_eff;

    assign we_eff = we_i && (waddr_i != ASIZE'(REG_ZERO));

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int unsigned i = 0; i < NRegs; i++) begin
                regs_q[i] <= '0;
            end
        end else if (we_eff) begin
            regs_q[waddr_i] <= wdata_i;
        end
    end

    // Write-first: a matching commit is visible in the same cycle.
    always_comb begin
        rdata1_o = regs_q[raddr1_i];
        if (raddr1_i == ASIZE'(REG_ZERO)) begin
            rdata1_o = '0;
        end else if (we_eff && (raddr1_i == waddr_i)) begin
            rdata1_o = wdata_i;
        end
    end

    always_comb begin
        rdata2_o = regs_q[raddr2_i];
        if (raddr2_i == ASIZE'(REG_ZERO)) begin
            rdata2_o = '0;
        end else if (we_eff && (raddr2_i == waddr_i)) begin
            rdata2_o = wdata_i;
        end
    end

endmodule

// File: rtl/wb_regfile.sv
// Writeback stage: selects ALU/load/link data, commits it to the register file,
// drives the EX forwarding bus and counts retired writes.
module wb_regfile
    import wb_regfile_pkg::*;
#(
    parameter int unsigned DSIZE       = DSIZE_DEF,
    parameter int unsigned ISIZE       = ISIZE_DEF,
    parameter int unsigned ASIZE       = ASIZE_DEF,
    parameter int unsigned LINK_OFFSET = LINK_OFFSET_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [DSIZE-1:0] aluout_in,
    input  logic [DSIZE-1:0] mem_rdata_in,
    input  logic             MemtoReg_in,
    input  logic             wen_in,
    input  logic             jal_in,
    input  logic [ISIZE-1:0] PC_in,
    input  logic [ASIZE-1:0] waddr_in,
    input  logic [ASIZE-1:0] raddr1,
    input  logic [ASIZE-1:0] raddr2,
    output logic [DSIZE-1:0] rdata1,
    output logic [DSIZE-1:0] rdata2,
    output logic             fwd_valid,
    output logic [ASIZE-1:0] fwd_addr,
    output logic [DSIZE-1:0] fwd_data,
    output logic [CNT_W-1:0] retire_cnt
);

    wb_sel_e          wb_sel;
    logic [ISIZE-1:0] link_pc;
    logic [DSIZE-1:0] wdata;
    logic             commit;
    logic [CNT_W-1:0] retire_q, retire_d;

    always_comb begin
        // Link wraps in PC width before being resized to the data width.
        link_pc = PC_in + ISIZE'(LINK_OFFSET);
        wb_sel  = wb_select(jal_in, MemtoReg_in);
        wdata   = aluout_in;
        unique case (wb_sel)
            WbLink:  wdata = DSIZE'(link_pc);
            WbMem:   wdata = mem_rdata_in;
            default: wdata = aluout_in;
        endcase
    end

    assign commit   = wen_in && (waddr_in != ASIZE'(REG_ZERO)) && !rst;
    assign retire_d = retire_q + CNT_W'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            retire_q <= '0;
        end else if (commit) begin
            retire_q <= retire_d;
        end
    end

    assign fwd_valid  = commit;
    assign fwd_addr   = waddr_in;
    assign fwd_data   = wdata;
    assign retire_cnt = retire_q;

    regfile_2r1w #(
        .DSIZE (DSIZE),
        .ASIZE (ASIZE)
    ) u_regfile (
        .clk_i    (clk),
        .rst_i    (rst),
        .we_i     (commit),
        .waddr_i  (waddr_in),
        .wdata_i  (wdata),
        .raddr1_i (raddr1),
        .raddr2_i (raddr2),
        .rdata1_o (rdata1),
        .rdata2_o (rdata2)
    );

endmodule

// File: tb/tb_wb_regfile.sv
// Scoreboard bench for wb_regfile: stimulus queues expected outputs, a monitor
// samples the DUT and compares.
module tb_wb_regfile;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] aluout_in, mem_rdata_in, PC_in;
    logic        MemtoReg_in, wen_in, jal_in;
    logic [4:0]  waddr_in, raddr1, raddr2;
    logic [31:0] rdata1, rdata2, fwd_data, retire_cnt;
    logic        fwd_valid;
    logic [4:0]  fwd_addr;

    always #5 clk = ~clk;

    wb_regfile dut (
        .clk          (clk),
        .rst          (rst),
        .aluout_in    (aluout_in),
        .mem_rdata_in (mem_rdata_in),
        .MemtoReg_in  (MemtoReg_in),
        .wen_in       (wen_in),
        .jal_in       (jal_in),
        .PC_in        (PC_in),
        .waddr_in     (waddr_in),
        .raddr1       (raddr1),
        .raddr2       (raddr2),
        .rdata1       (rdata1),
        .rdata2       (rdata2),
        .fwd_valid    (fwd_valid),
        .fwd_addr     (fwd_addr),
        .fwd_data     (fwd_data),
        .retire_cnt   (retire_cnt)
    );

    typedef enum int {SelRd1, SelRd2, SelFv, SelFa, SelFd, SelCnt} sel_e;
    typedef struct {
        string       name;
        sel_e        sel;
        logic [31:0] exp;
    } exp_t;

    exp_t queue_q[$];
    event sample_ev;
    int   checks = 0;
    int   errors = 0;

    // Monitor: samples 1 time unit after each stimulus point, well clear of posedge.
    initial begin
        forever begin
            @(sample_ev);
            #1;
            while (queue_q.size() > 0) begin
                exp_t        e;
                logic [31:0] act;
                e = queue_q.pop_front();
                case (e.sel)
                    SelRd1:  act = rdata1;
                    SelRd2:  act = rdata2;
                    SelFv:   act = {31'd0, fwd_valid};
                    SelFa:   act = {27'd0, fwd_addr};
                    SelFd:   act = fwd_data;
                    default: act = retire_cnt;
                endcase
                checks++;
                if (act !== e.exp) begin
                    errors++;
                    $display("FAIL %s: got 0x%08h expected 0x%08h", e.name, act, e.exp);
                end
            end
        end
    end

    task automatic expect_val(input string name, input sel_e sel, input logic [31:0] exp);
        exp_t e;
        e.name = name;
        e.sel  = sel;
        e.exp  = exp;
        queue_q.push_back(e);
    endtask

    task automatic drive(input logic wen, input logic m2r, input logic jal,
                         input logic [31:0] pc, input logic [31:0] alu,
                         input logic [31:0] mem, input logic [4:0] wa,
                         input logic [4:0] r1, input logic [4:0] r2);
        wen_in       = wen;
        MemtoReg_in  = m2r;
        jal_in       = jal;
        PC_in        = pc;
        aluout_in    = alu;
        mem_rdata_in = mem;
        waddr_in     = wa;
        raddr1       = r1;
        raddr2       = r2;
    endtask

    task automatic sample_and_advance();
        ->sample_ev;
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 5'd0, 5'd0, 5'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Preload r5 = 0x1234.
        drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h1234, 32'h0, 5'd5, 5'd5, 5'd0);
        expect_val("preload_bypass", SelRd1, 32'h1234);
        expect_val("preload_fwd_valid", SelFv, 32'd1);
        expect_val("preload_fwd_addr", SelFa, 32'd5);
        sample_and_advance();

        // Reset cycle with a pending write to r7: write must be suppressed.
        rst = 1'b1;
        drive(1'b1, 1'b0, 1'b0, 32'h0, 32'hAAAA, 32'h0, 5'd7, 5'd5, 5'd7);
        expect_val("rst_fwd_valid", SelFv, 32'd0);
        expect_val("rst_pre_r5", SelRd1, 32'h1234);
        expect_val("rst_pre_cnt", SelCnt, 32'd1);
        sample_and_advance();
        rst = 1'b0;

        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 5'd0, 5'd5, 5'd7);
        expect_val("post_rst_r5", SelRd1, 32'd0);
        expect_val("post_rst_r7", SelRd2, 32'd0);
        expect_val("post_rst_cnt", SelCnt, 32'd0);
        sample_and_advance();
        for (int i = 1; i < 32; i += 6) begin
            drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 5'd0, 5'(i), 5'(31 - i));
            expect_val("post_rst_sweep1", SelRd1, 32'd0);
            expect_val("post_rst_sweep2", SelRd2, 32'd0);
            sample_and_advance();
        end

        // ALU path.
        drive(1'b1, 1'b0, 1'b0, 32'h0, 32'hDEADBEEF, 32'h0, 5'd3, 5'd3, 5'd0);
        expect_val("alu_bypass", SelRd1, 32'hDEADBEEF);
        expect_val("alu_r0_port2", SelRd2, 32'd0);
        expect_val("alu_fwd_data", SelFd, 32'hDEADBEEF);
        sample_and_advance();
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 5'd0, 5'd3, 5'd0);
        expect_val("alu_array", SelRd1, 32'hDEADBEEF);
        expect_val("alu_cnt", SelCnt, 32'd1);
        sample_and_advance();

        // Load path.
        drive(1'b1, 1'b1, 1'b0, 32'h0, 32'h1111, 32'h55AA, 5'd4, 5'd0, 5'd4);
        expect_val("load_bypass", SelRd2, 32'h55AA);
        expect_val("load_fwd_data", SelFd, 32'h55AA);
        sample_and_advance();
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 5'd0, 5'd4, 5'd0);
        expect_val("load_array", SelRd1, 32'h55AA);
        expect_val("load_cnt", SelCnt, 32'd2);
        sample_and_advance();

        // jal overrides MemtoReg.
        drive(1'b1, 1'b1, 1'b1, 32'h100, 32'h2222, 32'h3333, 5'd31, 5'd0, 5'd0);
        expect_val("jal_fwd_data", SelFd, 32'h101);
        expect_val("jal_fwd_addr", SelFa, 32'd31);
        sample_and_advance();
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 5'd0, 5'd31, 5'd0);
        expect_val("jal_array", SelRd1, 32'h101);
        expect_val("jal_cnt", SelCnt, 32'd3);
        sample_and_advance();

        // Write to r0 is dropped.
        drive(1'b1, 1'b0, 1'b0, 32'h0, 32'hFFFFFFFF, 32'h0, 5'd0, 5'd0, 5'd0);
        expect_val("r0_read", SelRd1, 32'd0);
        expect_val("r0_fwd_valid", SelFv, 32'd0);
        sample_and_advance();
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 5'd0, 5'd0, 5'd0);
        expect_val("r0_read_after", SelRd2, 32'd0);
        expect_val("r0_cnt", SelCnt, 32'd3);
        sample_and_advance();

        // Back-to-back writes to r9, then an idle cycle with junk data.
        drive(1'b1, 1'b0, 1'b0, 32'h0, 32'd1, 32'h0, 5'd9, 5'd9, 5'd9);
        expect_val("b2b_first_p1", SelRd1, 32'd1);
        expect_val("b2b_first_p2", SelRd2, 32'd1);
        sample_and_advance();
        drive(1'b1, 1'b0, 1'b0, 32'h0, 32'd2, 32'h0, 5'd9, 5'd9, 5'd9);
        expect_val("b2b_second_p1", SelRd1, 32'd2);
        expect_val("b2b_second_p2", SelRd2, 32'd2);
        sample_and_advance();
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'd7, 32'h0, 5'd9, 5'd9, 5'd9);
        expect_val("idle_p1", SelRd1, 32'd2);
        expect_val("idle_fwd_valid", SelFv, 32'd0);
        sample_and_advance();
        expect_val("idle_next_p2", SelRd2, 32'd2);
        expect_val("b2b_cnt", SelCnt, 32'd5);
        sample_and_advance();

        // jal link wraps: r10 preset nonzero, then overwritten with 0.
        drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h77, 32'h0, 5'd10, 5'd10, 5'd0);
        expect_val("r10_preset", SelRd1, 32'h77);
        sample_and_advance();
        drive(1'b1, 1'b0, 1'b1, 32'hFFFFFFFF, 32'h9, 32'h0, 5'd10, 5'd10, 5'd0);
        expect_val("jal_wrap_fwd", SelFd, 32'd0);
        expect_val("jal_wrap_bypass", SelRd1, 32'd0);
        sample_and_advance();
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 5'd0, 5'd10, 5'd0);
        expect_val("jal_wrap_array", SelRd1, 32'd0);
        expect_val("jal_wrap_cnt", SelCnt, 32'd7);
        sample_and_advance();

        // Retire counter wrap.
        force dut.retire_q = 32'hFFFFFFFF;
        #1;
        release dut.retire_q;
        expect_val("cnt_forced", SelCnt, 32'hFFFFFFFF);
        sample_and_advance();
        drive(1'b1, 1'b0, 1'b0, 32'h0, 32'd5, 32'h0, 5'd12, 5'd12, 5'd0);
        expect_val("cnt_wrap_pre", SelCnt, 32'hFFFFFFFF);
        sample_and_advance();
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 5'd0, 5'd12, 5'd0);
        expect_val("cnt_wrap", SelCnt, 32'd0);
        expect_val("cnt_wrap_r12", SelRd1, 32'd5);
        ->sample_ev;
        #3;

        if (queue_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending entries expected 0", queue_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
